// File: rtl/puf_eval_ctrl_pkg.sv
// Shared types and helpers for the PUF evaluation sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RACE,
    SAMPLE,
    RELAX,
    DONE
  } pufState_e;

  localparam logic [15:0] LFSR_POLY_16 = 16'hB400;

  // Right-shifting Galois step. Operands are zero-extended, so any width up to 64 works.
  function automatic logic [63:0] lfsrNext(input logic [63:0] s, input logic [63:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 64'd0);
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_lfsr.sv
// Parameterized Galois LFSR. A load takes priority over a step, and a zero seed becomes 1.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int            W    = 16,
  parameter logic [W-1:0]  POLY = W'(LFSR_POLY_16)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // State register. An all-zero state never steps away, so it is never loaded.
  always_ff @(posedge clk) begin
    if (rst)       state <= '0;
    else if (load) state <= (seed == '0) ? ONE : seed;
    else if (step) state <= W'(lfsrNext(64'(state), 64'(POLY)));
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Drives the PUF slice chain: it holds a challenge, launches repeated races,
// majority-votes the synchronized result and packs one bit per challenge.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int                STAGES     = 16,
  parameter int                RW         = 32,
  parameter int                VOTES      = 5,
  parameter int                SETUP_CYC  = 4,
  parameter int                SETTLE_CYC = 8,
  parameter int                RELAX_CYC  = 4,
  parameter logic [STAGES-1:0] POLY       = STAGES'(LFSR_POLY_16)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STAGES-1:0] seed,
  input  logic              chain_out,
  output logic [STAGES-1:0] chal_sel,
  output logic [STAGES-1:0] chal_bx,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     response
);

  localparam int MAXC = (SETUP_CYC > SETTLE_CYC) ?
                        ((SETUP_CYC > RELAX_CYC) ? SETUP_CYC : RELAX_CYC) :
                        ((SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = (RW > 1) ? $clog2(RW) : 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RELAX_LAST  = CW'(RELAX_CYC - 1);
  localparam logic [VW-1:0] RACE_LAST   = VW'(VOTES - 1);
  localparam logic [VW-1:0] VOTE_HALF   = VW'(VOTES / 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RW - 1);

  pufState_e         state;
  logic [CW-1:0]     cycCnt;
  logic [VW-1:0]     voteCnt;
  logic [VW-1:0]     raceIdx;
  logic [BW-1:0]     bitIdx;
  logic [1:0]        syncPipe;
  logic              ldLfsr;
  logic              stepLfsr;
  logic [STAGES-1:0] lfsrQ;
  logic [STAGES-1:0] lfsrRev;

  // A start is accepted only in IDLE. It is refused in the cycle where done is still showing.
  assign ldLfsr   = (state == IDLE) && start && !done;
  // Move to the next challenge when the final relax of the last race for a bit ends.
  assign stepLfsr = (state == RELAX) && (cycCnt == RELAX_LAST) && (raceIdx == RACE_LAST);

  puf_lfsr #(.W(STAGES), .POLY(POLY)) uLfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (ldLfsr),
    .step  (stepLfsr),
    .seed  (seed),
    .state (lfsrQ)
  );

  for (genvar i = 0; i < STAGES; i++) begin : gRev
    assign lfsrRev[i] = lfsrQ[STAGES-1-i];
  end

  // Two-flop synchronizer for the chain's asynchronous terminal output.
  always_ff @(posedge clk) begin
    if (rst) syncPipe <= '0;
    else     syncPipe <= {syncPipe[0], chain_out};
  end

  // Challenge drive trails the LFSR by one cycle. With SETUP_CYC >= 2 it still settles while en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      chal_sel <= '0;
      chal_bx  <= '0;
    end else begin
      chal_sel <= lfsrQ;
      chal_bx  <= lfsrRev;
    end
  end

  // Sequencer: setup, then VOTES x (race, sample, relax) per bit, then done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cycCnt   <= '0;
      voteCnt  <= '0;
      raceIdx  <= '0;
      bitIdx   <= '0;
      response <= '0;
      chain_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            state    <= SETUP;
            cycCnt   <= '0;
            voteCnt  <= '0;
            raceIdx  <= '0;
            bitIdx   <= '0;
            response <= '0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cycCnt == SETUP_LAST) begin
            cycCnt   <= '0;
            state    <= RACE;
            chain_en <= 1'b1;
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        RACE: begin
          if (cycCnt == SETTLE_LAST) begin
            cycCnt <= '0;
            state  <= SAMPLE;
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        SAMPLE: begin
          voteCnt  <= voteCnt + VW'(syncPipe[1]);
          chain_en <= 1'b0;
          state    <= RELAX;
        end
        RELAX: begin
          if (cycCnt == RELAX_LAST) begin
            cycCnt <= '0;
            if (raceIdx != RACE_LAST) begin
              raceIdx  <= raceIdx + 1'b1;
              chain_en <= 1'b1;
              state    <= RACE;
            end else begin
              response[bitIdx] <= (voteCnt > VOTE_HALF);
              voteCnt          <= '0;
              raceIdx          <= '0;
              bitIdx           <= bitIdx + 1'b1;
              state            <= (bitIdx == BIT_LAST) ? DONE : SETUP;
            end
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequencer that drives a chain of enable-gated PUF delay slices and captures the chain's race result into a multi-bit response.
- Sits directly upstream of the slice chain, driving per-stage select/bx bits and the shared enable. Also consumes the chain's terminal output.
- Each response bit uses an LFSR-expanded challenge and is the majority vote of repeated races.

Parameters:
- STAGES, 16, number of slices in the chain; width of sel/bx drive vectors and of the LFSR.
- RW, 32, response width in bits.
- VOTES, 5, races per response bit; must be odd and >= 1.
- SETUP_CYC, 4, cycles the challenge is held with en=0 before launch.
- SETTLE_CYC, 8, cycles after launch before sampling; must be >= 3.
- RELAX_CYC, 4, cycles with en=0 after sampling, before the next race.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless IDLE.
- seed  in  STAGES  challenge seed, sampled when start is accepted.
- chain_out  in  1  terminal output of the slice chain; asynchronous to clk.
- chal_sel  out  STAGES  per-stage sel drive.
- chal_bx  out  STAGES  per-stage bx drive.
- chain_en  out  1  shared slice enable (race launch).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the response is valid.
- response  out  RW  captured response; holds its value until the next accepted start.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; chal_sel, chal_bx, response, lfsr all zero; chain_en, busy, done all 0. A reset mid-run aborts immediately with no done pulse.
- chain_out passes through a 2-flop synchronizer, reset to 0. The sample point is the synchronized value.
- LFSR: Galois, width STAGES, polynomial constant from the package. Load = seed; a zero seed is replaced with 1. chal_sel = lfsr and chal_bx = bit-reverse of lfsr, both registered.
- FSM states and transitions:
  - IDLE: on start, load the LFSR, clear response, bit_idx and vote_cnt, then go to SETUP.
  - SETUP: chain_en=0. After SETUP_CYC cycles, go to RACE.
  - RACE: chain_en=1. After SETTLE_CYC cycles, go to SAMPLE.
  - SAMPLE: one cycle; chain_en stays 1; vote_cnt += synchronized chain_out. Go to RELAX.
  - RELAX: chain_en=0 for RELAX_CYC cycles.
    - If races remain for this bit, go to RACE. The challenge is unchanged and SETUP is not repeated.
    - Otherwise, response[bit_idx] = (vote_cnt > VOTES/2). Clear vote_cnt, advance the LFSR once, increment bit_idx, and go to SETUP.
    - After bit RW-1 is written, go to DONE instead.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Widths: vote_cnt is $clog2(VOTES+1) bits, bit_idx is $clog2(RW) bits, and one shared cycle counter is sized for the largest *_CYC. Comparisons are unsigned.
- Response is filled LSB-first: bit 0 is the first evaluated challenge.
- Latency from start to done is exactly 1 + RW*(SETUP_CYC + VOTES*(SETTLE_CYC+1+RELAX_CYC)) + 1 cycles.
- start while busy is ignored. start in the DONE cycle is also ignored; accepting it in IDLE on the following cycle is allowed.
- chal_sel and chal_bx only change while chain_en=0, never during RACE or SAMPLE.
- Only registered outputs are used; no latches.

Decomposition:
- Package puf_pkg holds:
  - the FSM state enum typedef (IDLE, SETUP, RACE, SAMPLE, RELAX, DONE);
  - LFSR_POLY_16 = 16'hB400;
  - a function for the LFSR next state.
- One sub-module: puf_lfsr, a parameterized Galois LFSR with load and step inputs.
- The synchronizer stays inline.

Test Plan:
- Reset with chain_out tied to 1 -> outputs all 0, state IDLE. Pulse start with seed=16'h0001 -> busy=1 next cycle. For defaults, done arrives exactly 1+32*(4+5*13)+1 = 2210 cycles after the start cycle, and response=32'hFFFF_FFFF.
- chain_out tied to 0 -> response=0. With seed=16'h0000, chal_sel equals 16'h0001 in the first SETUP.
- Model drives chain_out=1 on 3 of 5 races for even bits and 2 of 5 for odd bits -> response=32'h5555_5555.
- Monitor chal_sel/chal_bx -> they never change while chain_en=1. After each bit, chal_sel equals the reference LFSR step (seed 16'hACE1 sequence matches the model), and chal_bx equals bit-reverse of chal_sel.
- Assert rst mid-RACE on bit 7 -> next cycle chain_en=0, busy=0, response=0, and no done pulse. A following start completes normally.
- Pulse start again while busy, and during DONE -> ignored: no restart, done pulses exactly once, and the latency count is unchanged.
